// File: rtl/dfe_round_pkg.sv
// Shared types and constants for the DFE rounding/saturation stage.
package dfe_round_pkg;

  localparam int SHIFT_W = 3;

  typedef enum logic [1:0] {
    RND_RNE     = 2'd0,
    RND_HALF_UP = 2'd1,
    RND_TRUNC   = 2'd2,
    RND_ZERO    = 2'd3
  } round_mode_e;

  function automatic longint out_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint out_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/round_sat_lane.sv
// One channel of the rounding/saturation datapath: stage 1 shifts and rounds,
// stage 2 clips to the output range and raises the clip flags.
module round_sat_lane
  import dfe_round_pkg::*;
#(
  parameter int ACC_WIDTH = 42,
  parameter int ACC_FRAC  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 15,
  parameter int MAX_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_s1_en,
  input  logic                        i_s2_en,
  input  logic signed [ACC_WIDTH-1:0] i_acc,
  input  logic [SHIFT_W-1:0]          i_shift,
  input  logic [1:0]                  i_mode,
  output logic [OUT_WIDTH-1:0]        o_data,
  output logic                        o_ovf,
  output logic                        o_unf
);

  localparam int SUM_W = ACC_WIDTH + 1;
  localparam int BASE  = ACC_FRAC - OUT_FRAC;
  localparam logic [SHIFT_W-1:0]      SHIFT_CAP = SHIFT_W'(MAX_SHIFT);
  localparam logic signed [SUM_W-1:0] SUM_MAX   = SUM_W'(out_max(OUT_WIDTH));
  localparam logic signed [SUM_W-1:0] SUM_MIN   = SUM_W'(out_min(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0]    SAT_HI    = OUT_WIDTH'(out_max(OUT_WIDTH));
  localparam logic [OUT_WIDTH-1:0]    SAT_LO    = OUT_WIDTH'(out_min(OUT_WIDTH));
  localparam logic [ACC_WIDTH-1:0]    ACC_ONE   = {{(ACC_WIDTH-1){1'b0}}, 1'b1};

  round_mode_e                 w_mode;
  logic [SHIFT_W-1:0]          w_shift;
  logic [7:0]                  w_t;
  logic signed [ACC_WIDTH-1:0] w_q;
  logic [ACC_WIDTH-1:0]        w_gmask;
  logic                        w_guard;
  logic                        w_sticky;
  logic                        w_inc;
  logic signed [SUM_W-1:0]     w_sum;
  logic signed [SUM_W-1:0]     r_sum;
  logic                        w_hi;
  logic                        w_lo;
  logic [OUT_WIDTH-1:0]        w_data;
  logic [OUT_WIDTH-1:0]        r_data;
  logic                        r_ovf;
  logic                        r_unf;

  assign w_mode  = round_mode_e'(i_mode);
  assign w_shift = (i_shift > SHIFT_CAP) ? SHIFT_CAP : i_shift;
  assign w_t     = 8'(BASE) + 8'(w_shift);
  assign w_q     = i_acc >>> w_t;
  // Guard is the bit just below the kept LSB; sticky is everything beneath it.
  assign w_gmask  = ACC_ONE << (w_t - 8'd1);
  assign w_guard  = |(i_acc & w_gmask);
  assign w_sticky = |(i_acc & (w_gmask - ACC_ONE));

  // Rounding increment for the selected mode; no fraction is dropped when T is 0.
  always_comb begin
    w_inc = 1'b0;
    if (w_t == 8'd0) begin
      w_inc = 1'b0;
    end else begin
      case (w_mode)
        RND_RNE:     w_inc = w_guard & (w_sticky | w_q[0]);
        RND_HALF_UP: w_inc = w_guard;
        RND_TRUNC:   w_inc = 1'b0;
        RND_ZERO:    w_inc = i_acc[ACC_WIDTH-1] & (w_guard | w_sticky);
        default:     w_inc = 1'b0;
      endcase
    end
  end

  assign w_sum = {w_q[ACC_WIDTH-1], w_q} + {{ACC_WIDTH{1'b0}}, w_inc};

  // Stage 1 register: rounded sum, one bit wider than the shifted word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= {SUM_W{1'b0}};
    end else if (i_s1_en) begin
      r_sum <= w_sum;
    end
  end

  assign w_hi = (r_sum > SUM_MAX);
  assign w_lo = (r_sum < SUM_MIN);

  // Clip selection for stage 2.
  always_comb begin
    w_data = r_sum[OUT_WIDTH-1:0];
    if (w_hi) begin
      w_data = SAT_HI;
    end else if (w_lo) begin
      w_data = SAT_LO;
    end else begin
      w_data = r_sum[OUT_WIDTH-1:0];
    end
  end

  // Stage 2 register: output word and its clip flags move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= {OUT_WIDTH{1'b0}};
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
    end else if (i_s2_en) begin
      r_data <= w_data;
      r_ovf  <= w_hi;
      r_unf  <= w_lo;
    end
  end

  assign o_data = r_data;
  assign o_ovf  = r_ovf;
  assign o_unf  = r_unf;

endmodule

// File: rtl/round_sat_pipe.sv
// Multi-channel two-stage round/saturate pipeline with valid/ready handshake.
// Optional SAT_COUNT_EN adds per-channel saturating clip counters (sat_count).
module round_sat_pipe
  import dfe_round_pkg::*;
#(
  parameter int ACC_WIDTH = 42,
  parameter int ACC_FRAC  = 32,
  parameter int OUT_WIDTH = 16,
  parameter int OUT_FRAC  = 15,
  parameter int NUM_CH    = 2,
  parameter int MAX_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*ACC_WIDTH-1:0] data_in,
  input  logic                        valid_in,
  output logic                        ready_out,
  input  logic [SHIFT_W-1:0]          shift_sel,
  input  logic [1:0]                  round_mode,
  input  logic                        clr_flags,
  output logic [NUM_CH*OUT_WIDTH-1:0] data_out,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [NUM_CH-1:0]           overflow,
  output logic [NUM_CH-1:0]           underflow,
  output logic [NUM_CH-1:0]           ovf_sticky
`ifdef SAT_COUNT_EN
  ,
  output logic [NUM_CH*16-1:0]        sat_count
`endif
);

  logic              r_s1_valid;
  logic              r_s2_valid;
  logic              w_s1_adv;
  logic              w_accept;
  logic              w_s2_load;
  logic              w_xfer;
  logic [NUM_CH-1:0] w_flag_xfer;
  logic [NUM_CH-1:0] w_sticky_nxt;
  logic [NUM_CH-1:0] r_sticky;

  assign w_s1_adv  = !r_s2_valid || ready_in;
  assign ready_out = !r_s1_valid || w_s1_adv;
  assign w_accept  = valid_in && ready_out;
  assign w_s2_load = w_s1_adv && r_s1_valid;
  assign w_xfer    = r_s2_valid && ready_in;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    round_sat_lane #(
      .ACC_WIDTH (ACC_WIDTH),
      .ACC_FRAC  (ACC_FRAC),
      .OUT_WIDTH (OUT_WIDTH),
      .OUT_FRAC  (OUT_FRAC),
      .MAX_SHIFT (MAX_SHIFT)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_s1_en (w_accept),
      .i_s2_en (w_s2_load),
      .i_acc   (data_in[c*ACC_WIDTH +: ACC_WIDTH]),
      .i_shift (shift_sel),
      .i_mode  (round_mode),
      .o_data  (data_out[c*OUT_WIDTH +: OUT_WIDTH]),
      .o_ovf   (overflow[c]),
      .o_unf   (underflow[c])
    );
  end

  // Stage occupancy; a stage empties only when its content moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
    end
  end

  assign valid_out = r_s2_valid;

  // A flagged beat that leaves in the same cycle as a clear keeps its bit set.
  assign w_flag_xfer  = {NUM_CH{w_xfer}} & (overflow | underflow);
  assign w_sticky_nxt = w_flag_xfer | (clr_flags ? {NUM_CH{1'b0}} : r_sticky);

  // Sticky clip flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= {NUM_CH{1'b0}};
    end else begin
      r_sticky <= w_sticky_nxt;
    end
  end

  assign ovf_sticky = r_sticky;

`ifdef SAT_COUNT_EN
  logic [NUM_CH*16-1:0] r_sat_cnt;

  // Per-channel clip counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= {(NUM_CH*16){1'b0}};
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr_flags) begin
          r_sat_cnt[c*16 +: 16] <= w_flag_xfer[c] ? 16'd1 : 16'd0;
        end else if (w_flag_xfer[c] && (r_sat_cnt[c*16 +: 16] != 16'hFFFF)) begin
          r_sat_cnt[c*16 +: 16] <= r_sat_cnt[c*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign sat_count = r_sat_cnt;
`endif

endmodule

// File: tb/tb_round_sat_pipe.sv
// Self-checking bench for round_sat_pipe: directed spec vectors, handshake
// scenarios and a randomized stream scored against an arithmetic reference.
module tb_round_sat_pipe;

  localparam int FRAC_DROP = 17;
  localparam int MAXSH     = 4;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  ov;
    logic [1:0]  un;
  } beat_t;

  localparam longint VA [10] = '{64'sh10000, 64'sh10000, 64'sh10000, 64'sh70000,
                                 -64'sh70000, 64'sh1_0000_0000, -64'sh1_0000_0000,
                                 -64'sh1_0002_0000, 64'sh1_0000_0000, 64'sh1_0000_0000};
  localparam int VSH [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 7};
  localparam int VMD [10] = '{0, 1, 2, 0, 3, 0, 0, 0, 0, 0};
  localparam logic [15:0] VEXP [10] = '{16'h0000, 16'h0001, 16'h0000, 16'h0004, 16'hFFFD,
                                        16'h7FFF, 16'h8000, 16'h8000, 16'h2000, 16'h0800};
  localparam bit VOV [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
  localparam bit VUN [10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [83:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  shift_sel;
  logic [1:0]  round_mode;
  logic        clr_flags;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic [1:0]  overflow;
  logic [1:0]  underflow;
  logic [1:0]  ovf_sticky;
`ifdef SAT_COUNT_EN
  logic [31:0] sat_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  round_sat_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .shift_sel  (shift_sel),
    .round_mode (round_mode),
    .clr_flags  (clr_flags),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .overflow   (overflow),
    .underflow  (underflow),
    .ovf_sticky (ovf_sticky)
`ifdef SAT_COUNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  // Reference: exact floor division, remainder compared with half a step, then clamp.
  function automatic void ref_beat(input longint acc, input int sh, input int md,
                                   output logic [15:0] y, output bit ov, output bit un);
    int     t;
    longint p, q, r, v;
    bit     inc;
    t = FRAC_DROP + ((sh > MAXSH) ? MAXSH : sh);
    p = 64'sd1 <<< t;
    q = acc / p;
    if (acc < 0 && q * p != acc) q = q - 1;
    r = acc - q * p;
    inc = 1'b0;
    if (t > 0) begin
      case (md)
        0: inc = (2 * r > p) || ((2 * r == p) && q[0]);
        1: inc = (2 * r >= p);
        2: inc = 1'b0;
        3: inc = (acc < 0) && (r != 0);
        default: inc = 1'b0;
      endcase
    end
    v  = q + longint'(inc);
    ov = (v > 32767);
    un = (v < -32768);
    if (ov) v = 32767;
    if (un) v = -32768;
    y = v[15:0];
  endfunction

  function automatic beat_t make_exp(input longint a0, input longint a1, input int sh, input int md);
    beat_t       b;
    logic [15:0] y0, y1;
    bit          o0, u0, o1, u1;
    ref_beat(a0, sh, md, y0, o0, u0);
    ref_beat(a1, sh, md, y1, o1, u1);
    b.d  = {y1, y0};
    b.ov = {o1, o0};
    b.un = {u1, u0};
    return b;
  endfunction

  function automatic longint rand_acc();
    longint v;
    v = {$urandom(), $urandom()};
    v = v >>> $urandom_range(22, 44);
    if ($urandom_range(0, 3) == 0) v = (v & ~64'sh1FFFF) | 64'sh10000;
    return v;
  endfunction

  task automatic run_single(input longint a0, input longint a1, input int sh, input int md,
                            output logic [31:0] d, output logic [1:0] ov,
                            output logic [1:0] un, output int lat);
    @(posedge clk); #1;
    data_in    = {a1[41:0], a0[41:0]};
    shift_sel  = 3'(sh);
    round_mode = 2'(md);
    valid_in   = 1'b1;
    ready_in   = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 0; d = 32'h0; ov = 2'b00; un = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (valid_out) begin
        lat = i; d = data_out; ov = overflow; un = underflow;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_in = 84'h0; valid_in = 1'b0; shift_sel = 3'd0;
    round_mode = 2'd0; clr_flags = 1'b0; ready_in = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || overflow !== 2'b00 ||
        underflow !== 2'b00 || ovf_sticky !== 2'b00) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b d=%h o=%b u=%b s=%b expected all zero",
               valid_out, data_out, overflow, underflow, ovf_sticky);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %b expected 1", ready_out);
    end
  endtask

  task automatic test_vectors();
    logic [31:0] d;
    logic [1:0]  ov, un;
    int          lat;
    longint      a1;
    beat_t       e;
    for (int i = 0; i < 10; i++) begin
      a1 = rand_acc();
      run_single(VA[i], a1, VSH[i], VMD[i], d, ov, un, lat);
      e = make_exp(VA[i], a1, VSH[i], VMD[i]);
      total++;
      if (lat !== 2) begin
        bad++;
        $display("FAIL vec%0d_latency: got %0d expected 2", i, lat);
      end
      total++;
      if (d[15:0] !== VEXP[i] || ov[0] !== VOV[i] || un[0] !== VUN[i]) begin
        bad++;
        $display("FAIL vec%0d_ch0: got d=%h o=%b u=%b expected d=%h o=%b u=%b",
                 i, d[15:0], ov[0], un[0], VEXP[i], VOV[i], VUN[i]);
      end
      total++;
      if (d[31:16] !== e.d[31:16] || ov[1] !== e.ov[1] || un[1] !== e.un[1]) begin
        bad++;
        $display("FAIL vec%0d_ch1: got d=%h o=%b u=%b expected d=%h o=%b u=%b",
                 i, d[31:16], ov[1], un[1], e.d[31:16], e.ov[1], e.un[1]);
      end
    end
  endtask

  task automatic test_sticky();
    logic [31:0] d;
    logic [1:0]  ov, un;
    int          lat;
    @(posedge clk); #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    run_single(-64'sh1_0002_0000, 64'sh0, 0, 0, d, ov, un, lat);
    repeat (4) @(negedge clk);
    total++;
    if (ovf_sticky !== 2'b01) begin
      bad++;
      $display("FAIL sticky_hold: got %b expected 01", ovf_sticky);
    end
    @(posedge clk); #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    @(negedge clk);
    total++;
    if (ovf_sticky !== 2'b00) begin
      bad++;
      $display("FAIL sticky_clear: got %b expected 00", ovf_sticky);
    end
    // Clear asserted in the very cycle the flagged beat leaves.
    @(posedge clk); #1;
    data_in = {42'h100000000, 42'h0}; shift_sel = 3'd0; round_mode = 2'd0;
    valid_in = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (valid_out !== 1'b1) begin
      bad++;
      $display("FAIL sticky_beat_valid: got %b expected 1", valid_out);
    end
    clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    @(negedge clk);
    total++;
    if (ovf_sticky !== 2'b10) begin
      bad++;
      $display("FAIL sticky_set_wins: got %b expected 10", ovf_sticky);
    end
    @(posedge clk); #1 clr_flags = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
  endtask

  task automatic test_stream(input int ncyc, input int vprob, input int rprob, input bit rclr,
                             output int n_acc, output int n_out);
    beat_t  expq[$];
    beat_t  e;
    bit     pending;
    longint a0, a1;
    int     sh, md;
    logic [1:0] msticky, fl;
    pending = 1'b0; n_acc = 0; n_out = 0; a0 = 0; a1 = 0; sh = 0; md = 0;
    @(posedge clk); #1 clr_flags = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
    @(posedge clk); #1 clr_flags = 1'b0;
    msticky = 2'b00;
    for (int cyc = 0; cyc < ncyc + 12; cyc++) begin
      @(posedge clk); #1;
      if (cyc < ncyc) begin
        if (!pending && int'($urandom_range(1, 100)) <= vprob) begin
          a0 = rand_acc(); a1 = rand_acc();
          sh = int'($urandom_range(0, 7)); md = int'($urandom_range(0, 3));
          data_in = {a1[41:0], a0[41:0]}; shift_sel = 3'(sh); round_mode = 2'(md);
          pending = 1'b1;
        end
        ready_in  = (int'($urandom_range(1, 100)) <= rprob);
        clr_flags = rclr && ($urandom_range(0, 7) == 0);
      end else begin
        ready_in  = 1'b1;
        clr_flags = 1'b0;
      end
      valid_in = pending;
      @(negedge clk);
      total++;
      if (ovf_sticky !== msticky) begin
        bad++;
        $display("FAIL stream_sticky cyc%0d: got %b expected %b", cyc, ovf_sticky, msticky);
      end
      fl = 2'b00;
      if (valid_out) begin
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL stream_spurious cyc%0d: got d=%h expected no beat", cyc, data_out);
        end else begin
          e = expq[0];
          if (data_out !== e.d || overflow !== e.ov || underflow !== e.un) begin
            bad++;
            $display("FAIL stream_data cyc%0d: got d=%h o=%b u=%b expected d=%h o=%b u=%b",
                     cyc, data_out, overflow, underflow, e.d, e.ov, e.un);
          end
          if (ready_in) begin
            void'(expq.pop_front());
            n_out++;
            fl = e.ov | e.un;
          end
        end
      end
      msticky = fl | (clr_flags ? 2'b00 : msticky);
      if (valid_in && ready_out) begin
        expq.push_back(make_exp(a0, a1, sh, md));
        pending = 1'b0;
        n_acc++;
      end
    end
    valid_in = 1'b0;
    total++;
    if (expq.size() != 0 || pending) begin
      bad++;
      $display("FAIL stream_drain: got %0d beats left expected 0", expq.size());
    end
  endtask

  task automatic test_back_to_back();
    int n_acc, n_out;
    test_stream(24, 100, 100, 1'b0, n_acc, n_out);
    total++;
    if (n_acc != 24 || n_out != 24) begin
      bad++;
      $display("FAIL b2b_throughput: got acc=%0d out=%0d expected 24/24", n_acc, n_out);
    end
  endtask

  task automatic test_random();
    int n_acc, n_out;
    test_stream(400, 70, 60, 1'b1, n_acc, n_out);
    total++;
    if (n_acc != n_out || n_acc < 50) begin
      bad++;
      $display("FAIL random_count: got acc=%0d out=%0d expected equal and >=50", n_acc, n_out);
    end
  endtask

  task automatic test_backpressure();
    longint ba0 [4], ba1 [4];
    int     bsh [4], bmd [4];
    beat_t  e [4];
    int     idx, got;
    for (int i = 0; i < 4; i++) begin
      ba0[i] = rand_acc(); ba1[i] = rand_acc();
      bsh[i] = int'($urandom_range(0, 7)); bmd[i] = int'($urandom_range(0, 3));
      e[i] = make_exp(ba0[i], ba1[i], bsh[i], bmd[i]);
    end
    idx = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(posedge clk); #1;
      ready_in = (cyc >= 5);
      if (idx < 4) begin
        data_in = {ba1[idx][41:0], ba0[idx][41:0]};
        shift_sel = 3'(bsh[idx]); round_mode = 2'(bmd[idx]); valid_in = 1'b1;
      end else begin
        valid_in = 1'b0;
      end
      @(negedge clk);
      if (cyc == 4) begin
        total++;
        if (idx != 2 || ready_out !== 1'b0 || valid_out !== 1'b1) begin
          bad++;
          $display("FAIL bp_stall: got acc=%0d ready_out=%b valid_out=%b expected 2/0/1",
                   idx, ready_out, valid_out);
        end
      end
      if (valid_out) begin
        total++;
        if (data_out !== e[got].d || overflow !== e[got].ov || underflow !== e[got].un) begin
          bad++;
          $display("FAIL bp_data%0d cyc%0d: got d=%h expected d=%h", got, cyc, data_out, e[got].d);
        end
        if (ready_in) got++;
      end
      if (valid_in && ready_out) idx++;
    end
    valid_in = 1'b0;
    total++;
    if (got != 4 || idx != 4) begin
      bad++;
      $display("FAIL bp_complete: got out=%0d acc=%0d expected 4/4", got, idx);
    end
  endtask

  task automatic test_reset_mid();
    int idx, seen;
    idx = 0; seen = 0;
    ready_in = 1'b0;
    for (int c = 0; c < 10 && idx < 2; c++) begin
      @(posedge clk); #1;
      data_in = {42'h100000000, 42'h3FEFFFE0000}; valid_in = 1'b1;
      @(negedge clk);
      if (ready_out) idx++;
    end
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b1 || ready_out !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_full: got valid_out=%b ready_out=%b expected 1/0", valid_out, ready_out);
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0 || data_out !== 32'h0 || overflow !== 2'b00 || ovf_sticky !== 2'b00) begin
      bad++;
      $display("FAIL rstmid_clear: got v=%b d=%h o=%b s=%b expected zeros",
               valid_out, data_out, overflow, ovf_sticky);
    end
    @(posedge clk); #1 rst_n = 1'b1; ready_in = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    total++;
    if (seen != 0 || ready_out !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_stale: got %0d stale beats ready_out=%b expected 0/1", seen, ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_sticky();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
